// File: rtl/multi_cycle_control.sv
// Moore control FSM for a multi-cycle processor: FETCH/DECODE plus per-class execute states.
// Define CTRL_ADDI_EN to enable the ADDI path (ADDIEX/ADDIWB); otherwise opcode 101 is illegal.
module multi_cycle_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] opcode,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       ALUSrcA,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADDR = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    REXEC   = 4'd7,
    RWB     = 4'd8,
    BRANCH  = 4'd9,
    JUMP    = 4'd10,
    ADDIEX  = 4'd11,
    ADDIWB  = 4'd12
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_J    = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;

`ifdef CTRL_ADDI_EN
  localparam logic ADDI_EN = 1'b1;
`else
  localparam logic ADDI_EN = 1'b0;
`endif

  state_t state_q, state_d;
  logic   is_sw;
  logic   illegal_q;
  logic   op_unsupported;

  assign op_unsupported = (opcode == 3'b110) || (opcode == 3'b111) ||
                          ((opcode == OP_ADDI) && !ADDI_EN);

  // NOTE: state elements use non-blocking assignments so every register samples
  // pre-edge values; the reset branch is sensitive to negedge reset, making it asynchronous.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      is_sw     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_q == DECODE) && op_unsupported;
      // LW/SW choice is frozen here so MEMADDR ignores later opcode changes
      if (state_q == DECODE) is_sw <= (opcode == OP_SW);
    end
  end

  // NOTE: every output and state_d gets a default before the case, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = FETCH;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    RegWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    ALUSrcA     = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
        state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_R:          state_d = REXEC;
          OP_LW, OP_SW:  state_d = MEMADDR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
`ifdef CTRL_ADDI_EN
          OP_ADDI:       state_d = ADDIEX;
`endif
          default:       state_d = FETCH;
        endcase
      end
      MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = is_sw ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = RWB;
      end
      RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef CTRL_ADDI_EN
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: RegWrite = 1'b1;
`endif
      default: state_d = FETCH;
    endcase
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: directed table, random opcode stream
// against an instruction-level reference model, and async-reset corner cases.
module tb_multi_cycle_control;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic       RegDst, MemtoReg, MemRead, MemWrite, IorD, RegWrite;
  logic       IRWrite, PCWrite, PCWriteCond, ALUSrcA, illegal;
  logic [3:0] state;
  logic [15:0] ctrl;

  multi_cycle_control dut (
    .clock(clock), .reset(reset), .opcode(opcode),
    .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .RegWrite(RegWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .ALUSrcA(ALUSrcA), .state(state), .illegal(illegal)
  );

  assign ctrl = {ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, MemRead, MemWrite,
                 IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA};

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   checks = 0;
  int   errors = 0;
  logic prev_ill = 1'b0;

  typedef struct {
    logic [2:0]      op;
    int              len;
    logic [4:0][3:0] seq;
    logic            ill;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic vec_t mk(input logic [2:0] op, input int len, input int s0, input int s1,
                              input int s2, input int s3, input int s4, input logic ill);
    vec_t v;
    v.op = op; v.len = len; v.ill = ill;
    v.seq[0] = 4'(s0); v.seq[1] = 4'(s1); v.seq[2] = 4'(s2);
    v.seq[3] = 4'(s3); v.seq[4] = 4'(s4);
    return v;
  endfunction

  // Expected strobes per state code, read straight off the per-state output lists
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st);
    logic [1:0] aluop, srcb, pcsrc;
    logic regdst, m2r, mrd, mwr, iord, rwr, irw, pcw, pcwc, srca;
    {aluop, srcb, pcsrc} = '0;
    {regdst, m2r, mrd, mwr, iord, rwr, irw, pcw, pcwc, srca} = '0;
    case (st)
      4'd1:  begin mrd = 1; irw = 1; pcw = 1; srcb = 2'b01; end
      4'd2:  srcb = 2'b11;
      4'd3:  begin srca = 1; srcb = 2'b10; end
      4'd4:  begin mrd = 1; iord = 1; end
      4'd5:  begin rwr = 1; m2r = 1; end
      4'd6:  begin mwr = 1; iord = 1; end
      4'd7:  begin srca = 1; aluop = 2'b10; end
      4'd8:  begin regdst = 1; rwr = 1; end
      4'd9:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
      4'd10: begin pcw = 1; pcsrc = 2'b10; end
`ifdef CTRL_ADDI_EN
      4'd11: begin srca = 1; srcb = 2'b10; end
      4'd12: rwr = 1;
`endif
      default: ;
    endcase
    return {aluop, srcb, pcsrc, regdst, m2r, mrd, mwr, iord, rwr, irw, pcw, pcwc, srca};
  endfunction

  // Instruction-level model: state walk derived from the instruction class
  task automatic get_path(input logic [2:0] op, output int len,
                          output logic [4:0][3:0] seq, output logic ill);
    int q[$];
    q = {1, 2};
    ill = 1'b0;
    case (op)
      3'd0: q = {q, 7, 8};
      3'd1: q = {q, 3, 4, 5};
      3'd2: q = {q, 3, 6};
      3'd3: q.push_back(9);
      3'd4: q.push_back(10);
`ifdef CTRL_ADDI_EN
      3'd5: q = {q, 11, 12};
`endif
      default: ill = 1'b1;
    endcase
    seq = '0;
    len = q.size();
    foreach (q[i]) seq[i] = 4'(q[i]);
  endtask

  task automatic run_instr(input logic [2:0] op, input int len, input logic [4:0][3:0] seq,
                           input logic ill, input bit scramble);
    for (int i = 0; i < len; i++) begin
      if (i == 0) opcode = op;
      else if (i >= 2 && scramble) opcode = 3'($urandom);
      check($sformatf("state op%0d cyc%0d", op, i), 32'(state), 32'(seq[i]));
      check($sformatf("ctrl op%0d cyc%0d", op, i), 32'(ctrl), 32'(exp_ctrl(seq[i])));
      check($sformatf("illegal op%0d cyc%0d", op, i), 32'(illegal),
            (i == 0) ? 32'(prev_ill) : 32'd0);
      check("memrd_memwr_excl", 32'(MemRead & MemWrite), 32'd0);
      check("pcw_pcwc_excl", 32'(PCWrite & PCWriteCond), 32'd0);
      step();
    end
    prev_ill = ill;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " state"}, 32'(state), 32'd0);
    check({name, " ctrl"}, 32'(ctrl), 32'd0);
    check({name, " illegal"}, 32'(illegal), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    check_all_zero("idle_before_edge");
    step();
    check("first_edge_fetch", 32'(state), 32'd1);
    prev_ill = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = mk(3'b000, 4, 1, 2, 7, 8, 0, 1'b0);
    vecs[1] = mk(3'b001, 5, 1, 2, 3, 4, 5, 1'b0);
    vecs[2] = mk(3'b010, 4, 1, 2, 3, 6, 0, 1'b0);
    vecs[3] = mk(3'b011, 3, 1, 2, 9, 0, 0, 1'b0);
    vecs[4] = mk(3'b100, 3, 1, 2, 10, 0, 0, 1'b0);
`ifdef CTRL_ADDI_EN
    vecs[5] = mk(3'b101, 4, 1, 2, 11, 12, 0, 1'b0);
`else
    vecs[5] = mk(3'b101, 2, 1, 2, 0, 0, 0, 1'b1);
`endif
    vecs[6] = mk(3'b110, 2, 1, 2, 0, 0, 0, 1'b1);
    vecs[7] = mk(3'b111, 2, 1, 2, 0, 0, 0, 1'b1);

    // Held in reset across a clock edge: everything stays zero
    #12;
    check_all_zero("in_reset");
    release_reset();

    foreach (vecs[k]) run_instr(vecs[k].op, vecs[k].len, vecs[k].seq, vecs[k].ill, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [2:0]      op;
      int              len;
      logic [4:0][3:0] seq;
      logic            ill;
      op = 3'($urandom_range(0, 7));
      get_path(op, len, seq, ill);
      run_instr(op, len, seq, ill, 1'b1);
    end

    // SW with opcode switched to LW during MEMADDR still stores
    opcode = 3'b010;
    check("sw_fetch_illegal", 32'(illegal), 32'(prev_ill));
    check("sw_fetch", 32'(state), 32'd1);
    step(); check("sw_decode", 32'(state), 32'd2);
    step(); check("sw_memaddr", 32'(state), 32'd3);
    opcode = 3'b001;
    step();
    check("sw_memwr", 32'(state), 32'd6);
    check("sw_memwrite", 32'(MemWrite), 32'd1);
    check("sw_iord", 32'(IorD), 32'd1);
    step();
    check("sw_back_fetch", 32'(state), 32'd1);
    check("sw_memwrite_one_cycle", 32'(MemWrite), 32'd0);

    // Asynchronous reset in the middle of MEMWR
    opcode = 3'b010;
    step(); step(); step();
    check("pre_reset_memwr", 32'(state), 32'd6);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset_memwr");
    release_reset();

    // Asynchronous reset clears a pending illegal pulse
    run_instr(3'b110, 2, vecs[6].seq, 1'b1, 1'b0);
    check("illegal_pulse", 32'(illegal), 32'd1);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset_illegal");
    release_reset();
    check("illegal_after_reset", 32'(illegal), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 The block SHALL expose the following ports: clock, input, 1, single system clock; all state updates on its rising edge.
REQ-002 The block SHALL expose: reset, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL expose: opcode, input, 3, instruction opcode (IR[15:13]) from the datapath.
REQ-004 The block SHALL expose: ALUOp, output, 2; ALUSrcB, output, 2; PCSource, output, 2.
REQ-005 The block SHALL expose: RegDst, MemtoReg, MemRead, MemWrite, IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA, all output, 1, datapath control strobes.
REQ-006 The block SHALL expose: state, output, 4, current FSM state code (debug).
REQ-007 The block SHALL expose: illegal, output, 1, one-cycle pulse on an unsupported opcode.

Function
REQ-008 The block SHALL be a Moore FSM; every output SHALL be a combinational decode of the state register only.
REQ-009 State codes SHALL be: IDLE=0, FETCH=1, DECODE=2, MEMADDR=3, MEMRD=4, MEMWB=5, MEMWR=6, REXEC=7, RWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12.
REQ-010 Opcodes SHALL be: 000 R-type, 001 LW, 010 SW, 011 BEQ, 100 J, 101 ADDI; 110 and 111 are unsupported.
REQ-011 Outputs not listed for a state SHALL be 0.
REQ-012 IDLE SHALL assert all outputs 0 and advance unconditionally to FETCH.
REQ-013 FETCH SHALL assert MemRead=1, IRWrite=1, PCWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, then advance to DECODE.
REQ-014 DECODE SHALL assert ALUSrcA=0, ALUSrcB=11, ALUOp=00, and branch on opcode sampled that cycle: LW/SW->MEMADDR, R->REXEC, BEQ->BRANCH, J->JUMP, ADDI->ADDIEX, unsupported->FETCH.
REQ-015 MEMADDR SHALL assert ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD on LW and MEMWR on SW.
REQ-016 The LW/SW choice in MEMADDR SHALL use a 1-bit flag latched in DECODE, not the live opcode.
REQ-017 MEMRD SHALL assert MemRead=1, IorD=1, then go to MEMWB.
REQ-018 MEMWB SHALL assert RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-019 MEMWR SHALL assert MemWrite=1, IorD=1, then go to FETCH.
REQ-020 REXEC SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RWB.
REQ-021 RWB SHALL assert RegDst=1, RegWrite=1, MemtoReg=0, then go to FETCH.
REQ-022 BRANCH SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-023 JUMP SHALL assert PCWrite=1, PCSource=10, then go to FETCH.
REQ-024 Instruction latency SHALL be: LW 5 cycles; SW, R, ADDI 4 cycles; BEQ, J 3 cycles (FETCH through last state).
REQ-025 illegal SHALL be 1 exactly in the cycle after DECODE sees an unsupported opcode (registered), else 0.
REQ-026 MemRead and MemWrite SHALL never be 1 in the same cycle.
REQ-027 PCWrite and PCWriteCond SHALL never be 1 in the same cycle.
REQ-028 Unreachable state codes 13-15 SHALL transition to FETCH with all outputs 0.

Reset
REQ-029 reset low SHALL immediately force state=IDLE, the LW/SW flag=0, and illegal=0, independent of clock.
REQ-030 While reset is low, all outputs SHALL be 0, including mid-instruction (e.g. during MEMWR).
REQ-031 The first rising edge with reset high SHALL move IDLE->FETCH.

Configuration
REQ-032 Macro CTRL_ADDI_EN SHALL gate ADDI support.
REQ-033 With CTRL_ADDI_EN defined, opcode 101 SHALL run DECODE->ADDIEX->ADDIWB->FETCH. ADDIEX asserts ALUSrcA=1, ALUSrcB=10, ALUOp=00. ADDIWB asserts RegDst=0, RegWrite=1, MemtoReg=0.
REQ-034 With CTRL_ADDI_EN undefined, opcode 101 SHALL be unsupported (DECODE->FETCH, illegal pulse), and states 11/12 SHALL be treated as unreachable.

Verification
REQ-035 Reset release, opcode=000 -> state 0,1,2,7,8,1; RegWrite=1 and RegDst=1 only in state 8.
REQ-036 opcode=001 -> states 1,2,3,4,5,1; MemRead=1 in states 1 and 4; MemtoReg=1 only in 5; 5-cycle period.
REQ-037 opcode=010, with opcode changed to 001 during MEMADDR -> still goes to MEMWR (6); MemWrite=1 for one cycle, IorD=1.
REQ-038 opcode=011 -> states 1,2,9,1; PCWriteCond=1, PCSource=01 in 9. opcode=100 -> JUMP with PCWrite=1, PCSource=10.
REQ-039 opcode=110 -> DECODE->FETCH, illegal=1 for exactly one cycle. opcode=101 -> ADDIEX/ADDIWB with macro, illegal pulse without.
REQ-040 reset driven low asynchronously mid-MEMWR -> state=0 and all outputs 0 before the next clock edge.
